// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional two-entry skid buffer, stall-vector control,
// synchronous flush and a saturating bubble counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W  = 160,
    parameter int unsigned STALL_W = 6,
    parameter int unsigned STAGE   = 2,
    parameter int unsigned SKID    = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [DATA_W-1:0]  in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    input  logic               out_ready,
    output logic [1:0]         occupancy,
    output logic [15:0]        bubble_cnt
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StBusy  = 2'd1,
        StFull  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic [1:0]        occ_q, occ_d;
    logic [15:0]       bubble_q;
    logic              rdy_en_q;
    logic              stop_here;
    logic              stop_next;
    logic              accept;
    logic              drain;

    assign stop_here = stall[STAGE];
    assign stop_next = stall[STAGE+1];

    assign out_valid  = (state_q != StEmpty);
    // Vacated entries are always zeroed, so main_q already reads as NOP when empty.
    assign out_data   = main_q;
    assign occupancy  = occ_q;
    assign bubble_cnt = bubble_q;

    assign drain  = out_valid & out_ready & ~stop_next;
    assign accept = in_valid & in_ready;

    // rdy_en_q keeps in_ready low until the first edge after reset is released.
    always_comb begin
        in_ready = 1'b0;
        if (SKID != 0) begin
            in_ready = rdy_en_q & ~stop_here & (state_q != StFull);
        end else begin
            in_ready = rdy_en_q & ~stop_here & (~out_valid | drain);
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = StEmpty;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = StBusy;
                    end
                end
                StBusy: begin
                    if (accept && drain) begin
                        main_d = in_data;
                    end else if (accept && (SKID != 0)) begin
                        skid_d  = in_data;
                        state_d = StFull;
                    end else if (drain) begin
                        main_d  = '0;
                        state_d = StEmpty;
                    end
                end
                StFull: begin
                    if (drain) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = StBusy;
                    end
                end
                default: begin
                    state_d = StEmpty;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        occ_d = 2'd0;
        case (state_d)
            StBusy:  occ_d = 2'd1;
            StFull:  occ_d = 2'd2;
            default: occ_d = 2'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StEmpty;
            main_q   <= '0;
            skid_q   <= '0;
            occ_q    <= 2'd0;
            bubble_q <= 16'd0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            occ_q    <= occ_d;
            rdy_en_q <= 1'b1;
            if (!out_valid && (bubble_q != 16'hFFFF)) begin
                bubble_q <= bubble_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Random and directed stimulus against a queue-level reference model; the SKID=1 and
// SKID=0 builds share the same inputs and each has its own model.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          rdy   [2];
    logic          ov    [2];
    logic [DW-1:0] od    [2];
    logic [1:0]    occ   [2];
    logic [15:0]   bc    [2];

    // Reference model: per build, an ordered list of held entries and a bubble count.
    logic [DW-1:0] ment  [2][2];
    int            mcnt  [2];
    int            mbub  [2];
    bit            rdy_en;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .STALL_W(6), .STAGE(2), .SKID(1)) dut_skid (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
        .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready),
        .occupancy(occ[0]), .bubble_cnt(bc[0])
    );

    pipe_stage_reg #(.DATA_W(DW), .STALL_W(6), .STAGE(2), .SKID(0)) dut_reg (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
        .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready),
        .occupancy(occ[1]), .bubble_cnt(bc[1])
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mcnt[m] = 0;
            mbub[m] = 0;
            ment[m][0] = '0;
            ment[m][1] = '0;
        end
        rdy_en = 1'b0;
    endtask

    task automatic drive(input logic [5:0] st, input logic fl, input logic iv,
                         input logic [DW-1:0] id, input logic ordy);
        stall     = st;
        flush     = fl;
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
    endtask

    // Called just after a falling edge with inputs applied; checks, then crosses one edge.
    task automatic step();
        bit            ev, drn, rd;
        bit            acc [2];
        bit            dr  [2];
        logic [DW-1:0] ed;
        #1;
        for (int m = 0; m < 2; m++) begin
            ev  = (mcnt[m] != 0);
            ed  = ev ? ment[m][0] : '0;
            drn = ev && out_ready && !stall[3];
            if (m == 0) rd = rdy_en && !stall[2] && (mcnt[m] < 2);
            else        rd = rdy_en && !stall[2] && ((mcnt[m] == 0) || drn);
            acc[m] = in_valid && rd;
            dr[m]  = drn;
            check_eq($sformatf("in_ready[%0d]", m), 64'(rdy[m]), 64'(rd));
            check_eq($sformatf("out_valid[%0d]", m), 64'(ov[m]), 64'(ev));
            check_eq($sformatf("out_data[%0d]", m), 64'(od[m]), 64'(ed));
            check_eq($sformatf("occupancy[%0d]", m), 64'(occ[m]), 64'(mcnt[m]));
            check_eq($sformatf("bubble_cnt[%0d]", m), 64'(bc[m]), 64'(mbub[m]));
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (mcnt[m] == 0 && mbub[m] < 65535) mbub[m]++;
            if (flush) begin
                mcnt[m] = 0;
                ment[m][0] = '0;
                ment[m][1] = '0;
            end else begin
                if (dr[m]) begin
                    ment[m][0] = ment[m][1];
                    ment[m][1] = '0;
                    mcnt[m]--;
                end
                if (acc[m]) begin
                    ment[m][mcnt[m]] = in_data;
                    mcnt[m]++;
                end
            end
        end
        rdy_en = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        drive(6'b0, 1'b0, 1'b0, '0, 1'b0);
        model_reset();
        #2;
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("rst_in_ready[%0d]", m), 64'(rdy[m]), 64'd0);
            check_eq($sformatf("rst_out_valid[%0d]", m), 64'(ov[m]), 64'd0);
            check_eq($sformatf("rst_out_data[%0d]", m), 64'(od[m]), 64'd0);
            check_eq($sformatf("rst_occupancy[%0d]", m), 64'(occ[m]), 64'd0);
            check_eq($sformatf("rst_bubble_cnt[%0d]", m), 64'(bc[m]), 64'd0);
        end
        #6 rst = 1'b1;
        @(negedge clk);
        step();

        // Stream: back-to-back accepts with a free downstream.
        for (int i = 1; i <= 4; i++) begin
            drive(6'b0, 1'b0, 1'b1, DW'(32'h11 * i), 1'b1);
            step();
        end
        drive(6'b0, 1'b0, 1'b0, '0, 1'b1);
        step();
        step();

        // Backpressure: two accepts with out_ready low, then release.
        drive(6'b0, 1'b0, 1'b1, 32'h11, 1'b0);
        step();
        drive(6'b0, 1'b0, 1'b1, 32'h22, 1'b0);
        step();
        drive(6'b0, 1'b0, 1'b0, '0, 1'b0);
        step();
        drive(6'b0, 1'b0, 1'b0, '0, 1'b1);
        repeat (3) step();

        // Stall bubble: this stage stopped, downstream free.
        drive(6'b0, 1'b0, 1'b1, 32'hAB, 1'b1);
        step();
        drive(6'b000100, 1'b0, 1'b1, 32'h99, 1'b1);
        step();
        drive(6'b0, 1'b0, 1'b0, '0, 1'b1);
        step();

        // Stall hold: this stage and downstream stopped.
        drive(6'b0, 1'b0, 1'b1, 32'hCD, 1'b1);
        step();
        drive(6'b001100, 1'b0, 1'b1, 32'h77, 1'b1);
        repeat (3) step();
        drive(6'b0, 1'b0, 1'b0, '0, 1'b1);
        repeat (2) step();

        // Flush while full, with a coincident accept attempt.
        drive(6'b0, 1'b0, 1'b1, 32'h01, 1'b0);
        step();
        drive(6'b0, 1'b0, 1'b1, 32'h02, 1'b0);
        step();
        drive(6'b0, 1'b1, 1'b1, 32'h03, 1'b0);
        step();
        drive(6'b0, 1'b0, 1'b0, '0, 1'b1);
        repeat (2) step();

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 4) == 0) ? 6'($urandom) : 6'b0,
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 9) < 7),
                  DW'($urandom),
                  ($urandom_range(0, 9) < 6));
            step();
        end

        // Asynchronous reset between edges while holding entries.
        drive(6'b0, 1'b0, 1'b1, 32'h5A, 1'b0);
        step();
        drive(6'b0, 1'b0, 1'b1, 32'h6B, 1'b0);
        step();
        drive(6'b0, 1'b0, 1'b0, '0, 1'b0);
        #1 rst = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            check_eq($sformatf("arst_in_ready[%0d]", m), 64'(rdy[m]), 64'd0);
            check_eq($sformatf("arst_out_valid[%0d]", m), 64'(ov[m]), 64'd0);
            check_eq($sformatf("arst_out_data[%0d]", m), 64'(od[m]), 64'd0);
            check_eq($sformatf("arst_occupancy[%0d]", m), 64'(occ[m]), 64'd0);
            check_eq($sformatf("arst_bubble_cnt[%0d]", m), 64'(bc[m]), 64'd0);
        end
        model_reset();
        #1 rst = 1'b1;
        step();
        for (int i = 1; i <= 4; i++) begin
            drive(6'b0, 1'b0, 1'b1, DW'(32'h11 * i), 1'b1);
            step();
        end
        drive(6'b0, 1'b0, 1'b0, '0, 1'b1);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
